// File: rtl/hps_ext_arb_if.sv
// hps_ext_arb_if -- Avalon-MM style master port shared with the core-bus arbiter.
//
// One instance per internal bus master. The master modport is the issuing side
// (bus master), the slave modport is the arbiter side.
//
// Handshake: a request (read or write high) is accepted in the cycle where
// waitrequest is low; the master must hold address/writedata/strobes stable
// while waitrequest is high. Each accepted read returns exactly one
// readdatavalid pulse, in issue order, with readdata valid in that cycle.
//
// Signals:
//   address, writedata, read, write   master -> arbiter
//   waitrequest, readdata, readdatavalid  arbiter -> master
interface hps_ext_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic          read;
  logic          write;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  modport master (
    output address, writedata, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, read, write,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/hps_ext_arb.sv
// hps_ext_arb -- shares the hps_ext core register bus between the HPS ext port
// and two internal Avalon-MM masters (m0, m1).
//
// The HPS has absolute priority and is forwarded combinationally, so its timing
// on the core bus is unchanged. In cycles the HPS leaves idle, m0 and m1 are
// served round-robin, one access per cycle. Every issued read pushes a tag
// {valid, id} into an RD_LAT-deep pipeline so the fixed-latency read data can be
// steered back to whoever issued it.
//
// Ports:
//   clk_sys, reset_n          clock, asynchronous active-low reset
//   hps_addr/wdata/rd/wr      HPS ext side request (single-cycle strobes)
//   hps_rdata                 registered HPS read data, held until next HPS read
//   m0, m1                    Avalon-MM master ports (slave modport)
//   bus_addr/wdata/rd/wr      core bus request
//   bus_rdata                 core bus read data, valid RD_LAT cycles after bus_rd
module hps_ext_arb #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] hps_addr,
  input  logic [DW-1:0] hps_wdata,
  input  logic          hps_rd,
  input  logic          hps_wr,
  output logic [DW-1:0] hps_rdata,
  hps_ext_arb_if.slave  m0,
  hps_ext_arb_if.slave  m1,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic          bus_rd,
  output logic          bus_wr,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [1:0] ID_HPS = 2'd0;
  localparam logic [1:0] ID_M0  = 2'd1;
  localparam logic [1:0] ID_M1  = 2'd2;

  logic              hps_req;
  logic              m0_req;
  logic              m1_req;
  logic              gnt0;
  logic              gnt1;
  logic              last;      // 0 = m0 served last, 1 = m1 served last
  logic [1:0]        iss_id;
  logic [RD_LAT-1:0] tag_v;
  logic [1:0]        tag_id [RD_LAT];
  logic              out_v;
  logic [1:0]        out_id;

  assign hps_req = hps_rd | hps_wr;
  assign m0_req  = m0.read | m0.write;
  assign m1_req  = m1.read | m1.write;

  // Grant: HPS blocks both masters; on a tie the master that was not served
  // last wins. Everything is gated by reset_n so nothing is accepted in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n && !hps_req) begin
      if (m0_req && m1_req) begin
        gnt0 = last;
        gnt1 = ~last;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  // Bus mux. A master asserting read and write together issues a write only.
  always_comb begin
    bus_addr  = m0.address;
    bus_wdata = m0.writedata;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    iss_id    = ID_HPS;
    if (hps_req) begin
      bus_addr  = hps_addr;
      bus_wdata = hps_wdata;
      bus_rd    = hps_rd;
      bus_wr    = hps_wr;
      iss_id    = ID_HPS;
    end else if (gnt0) begin
      bus_rd    = m0.read & ~m0.write;
      bus_wr    = m0.write;
      iss_id    = ID_M0;
    end else if (gnt1) begin
      bus_addr  = m1.address;
      bus_wdata = m1.writedata;
      bus_rd    = m1.read & ~m1.write;
      bus_wr    = m1.write;
      iss_id    = ID_M1;
    end
    if (!reset_n) begin
      bus_rd = 1'b0;
      bus_wr = 1'b0;
    end
  end

  // Round-robin pointer, read tag pipeline and HPS data capture.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      last      <= 1'b1;
      tag_v     <= '0;
      hps_rdata <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_id[i] <= ID_HPS;
      end
    end else begin
      if (gnt0) begin
        last <= 1'b0;
      end else if (gnt1) begin
        last <= 1'b1;
      end
      tag_v[0]  <= bus_rd;
      tag_id[0] <= iss_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      // Capturing here isolates HPS data from any master read that follows.
      if (out_v && out_id == ID_HPS) begin
        hps_rdata <= bus_rdata;
      end
    end
  end

  // The last pipeline stage lines up with bus_rdata for the read it tags.
  assign out_v  = tag_v[RD_LAT-1];
  assign out_id = tag_id[RD_LAT-1];

  assign m0.waitrequest   = ~gnt0;
  assign m1.waitrequest   = ~gnt1;
  assign m0.readdatavalid = reset_n & out_v & (out_id == ID_M0);
  assign m1.readdatavalid = reset_n & out_v & (out_id == ID_M1);
  assign m0.readdata      = reset_n ? bus_rdata : '0;
  assign m1.readdata      = reset_n ? bus_rdata : '0;

endmodule

// File: tb/tb_hps_ext_arb.sv
// tb_hps_ext_arb -- directed bench for hps_ext_arb.
//
// Three DUT copies (RD_LAT = 1, 2, 3) share one stimulus; each has its own
// fixed-latency core-bus responder returning mem[addr[3:0]]. Combinational
// issue/grant behaviour is checked from a vector table, read return and reset
// corner cases from hand-written sequences.
module tb_hps_ext_arb;
  localparam int AW = 16;
  localparam int DW = 32;

  // clock / reset
  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  // shared stimulus
  logic [AW-1:0] hps_addr;
  logic [DW-1:0] hps_wdata;
  logic          hps_rd;
  logic          hps_wr;
  logic [AW-1:0] m0_address;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m0_writedata;
  logic [DW-1:0] m1_writedata;
  logic          m0_read;
  logic          m0_write;
  logic          m1_read;
  logic          m1_write;
  logic [DW-1:0] mem [16];

  assign m0_writedata = 32'hA000_0000 | {16'h0, m0_address};
  assign m1_writedata = 32'hB000_0000 | {16'h0, m1_address};

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT = g + 1;
    hps_ext_arb_if #(.AW(AW), .DW(DW)) m0_if ();
    hps_ext_arb_if #(.AW(AW), .DW(DW)) m1_if ();
    logic [DW-1:0] hps_rdata;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_rd;
    logic          bus_wr;
    logic [DW-1:0] bus_rdata;
    logic [DW-1:0] rsp_q [LAT];

    assign m0_if.address   = m0_address;
    assign m0_if.writedata = m0_writedata;
    assign m0_if.read      = m0_read;
    assign m0_if.write     = m0_write;
    assign m1_if.address   = m1_address;
    assign m1_if.writedata = m1_writedata;
    assign m1_if.read      = m1_read;
    assign m1_if.write     = m1_write;

    // core-bus responder: data for a read at t is on bus_rdata at t+LAT
    always_ff @(posedge clk_sys) begin
      rsp_q[0] <= bus_rd ? mem[bus_addr[3:0]] : 32'h0BAD_0BAD;
      for (int i = 1; i < LAT; i++) begin
        rsp_q[i] <= rsp_q[i-1];
      end
    end
    assign bus_rdata = rsp_q[LAT-1];

    hps_ext_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .hps_addr  (hps_addr),
      .hps_wdata (hps_wdata),
      .hps_rd    (hps_rd),
      .hps_wr    (hps_wr),
      .hps_rdata (hps_rdata),
      .m0        (m0_if),
      .m1        (m1_if),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rd    (bus_rd),
      .bus_wr    (bus_wr),
      .bus_rdata (bus_rdata)
    );
  end

  // scoreboard
  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    hps_rd = 1'b0; hps_wr = 1'b0; hps_addr = '0; hps_wdata = '0;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  typedef struct {
    string         name;
    logic          hrd, hwr;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic          m0r, m0w;
    logic [AW-1:0] m0a;
    logic          m1r, m1w;
    logic [AW-1:0] m1a;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_w0, e_w1;
  } vec_t;

  vec_t vecs [$];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1111_1111 * i;
    idle();
    reset_n = 1'b0;

    // reset state, with requests present that must be blocked
    #1;
    hps_wr = 1'b1; m0_write = 1'b1; m1_read = 1'b1;
    @(negedge clk_sys);
    chk("rst_bus_wr", {31'b0, u[0].bus_wr}, 32'd0);
    chk("rst_bus_rd", {31'b0, u[0].bus_rd}, 32'd0);
    chk("rst_m0_wait", {31'b0, u[0].m0_if.waitrequest}, 32'd1);
    chk("rst_m1_wait", {31'b0, u[0].m1_if.waitrequest}, 32'd1);
    chk("rst_m0_rdv", {31'b0, u[0].m0_if.readdatavalid}, 32'd0);
    chk("rst_hps_rdata", u[0].hps_rdata, 32'd0);
    do_reset();

    // ---- vector table: combinational issue/grant, RR pointer starts at m0 ----
    //                  name           hrd   hwr   haddr     hwdata         m0r   m0w   m0a       m1r   m1w   m1a       e_rd  e_wr  e_addr    e_wdata        w0    w1
    vecs.push_back('{"hps_wr",       1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b1, 1'b1});
    vecs.push_back('{"hps_wr_m1",    1'b0, 1'b1, 16'h0020, 32'h12345678, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 16'h0020, 32'h12345678, 1'b1, 1'b1});
    vecs.push_back('{"m1_after_hps", 1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 16'h0030, 32'hB0000030, 1'b1, 1'b0});
    vecs.push_back('{"rr_m0_a",      1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 1'b1, 16'h0040, 32'hA0000040, 1'b0, 1'b1});
    vecs.push_back('{"rr_m1_a",      1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 1'b1, 16'h0050, 32'hB0000050, 1'b1, 1'b0});
    vecs.push_back('{"rr_m0_b",      1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 1'b1, 16'h0040, 32'hA0000040, 1'b0, 1'b1});
    vecs.push_back('{"rr_m1_b",      1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0050, 1'b0, 1'b1, 16'h0050, 32'hB0000050, 1'b1, 1'b0});
    vecs.push_back('{"m0_rd_and_wr", 1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b1, 1'b1, 16'h0060, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0060, 32'hA0000060, 1'b0, 1'b1});
    vecs.push_back('{"no_request",   1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b0, 16'h0070, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0070, 32'hA0000070, 1'b1, 1'b1});
    vecs.push_back('{"rr_m1_c",      1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1, 16'h0080, 32'hB0000080, 1'b1, 1'b0});
    vecs.push_back('{"hps_rd_both",  1'b1, 1'b0, 16'h0001, 32'h00000000, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h0001, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{"m0_rd",        1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 32'hA0000002, 1'b0, 1'b1});
    vecs.push_back('{"both_rd_m1",   1'b0, 1'b0, 16'h0000, 32'h00000000, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 16'h0003, 32'hB0000003, 1'b1, 1'b0});

    foreach (vecs[k]) begin
      hps_rd = vecs[k].hrd; hps_wr = vecs[k].hwr;
      hps_addr = vecs[k].haddr; hps_wdata = vecs[k].hwdata;
      m0_read = vecs[k].m0r; m0_write = vecs[k].m0w; m0_address = vecs[k].m0a;
      m1_read = vecs[k].m1r; m1_write = vecs[k].m1w; m1_address = vecs[k].m1a;
      @(negedge clk_sys);
      chk({vecs[k].name, ".bus_rd"}, {31'b0, u[0].bus_rd}, {31'b0, vecs[k].e_rd});
      chk({vecs[k].name, ".bus_wr"}, {31'b0, u[0].bus_wr}, {31'b0, vecs[k].e_wr});
      chk({vecs[k].name, ".bus_addr"}, {16'b0, u[0].bus_addr}, {16'b0, vecs[k].e_addr});
      chk({vecs[k].name, ".bus_wdata"}, u[0].bus_wdata, vecs[k].e_wdata);
      chk({vecs[k].name, ".m0_wait"}, {31'b0, u[0].m0_if.waitrequest}, {31'b0, vecs[k].e_w0});
      chk({vecs[k].name, ".m1_wait"}, {31'b0, u[0].m1_if.waitrequest}, {31'b0, vecs[k].e_w1});
      next_cycle();
    end

    // ---- HPS read at t, m0 read at t+1, RD_LAT=1 ----
    do_reset();
    hps_rd = 1'b1; hps_addr = 16'h0001;                 // t
    next_cycle();
    idle(); m0_read = 1'b1; m0_address = 16'h0002;     // t+1
    @(negedge clk_sys);
    chk("hm.t1_m0_wait", {31'b0, u[0].m0_if.waitrequest}, 32'd0);
    chk("hm.t1_m0_rdv", {31'b0, u[0].m0_if.readdatavalid}, 32'd0);
    chk("hm.t1_hps_rdata", u[0].hps_rdata, 32'd0);
    next_cycle();
    idle();                                             // t+2
    @(negedge clk_sys);
    chk("hm.t2_hps_rdata", u[0].hps_rdata, 32'h1111_1111);
    chk("hm.t2_m0_rdv", {31'b0, u[0].m0_if.readdatavalid}, 32'd1);
    chk("hm.t2_m0_rdata", u[0].m0_if.readdata, 32'h2222_2222);
    chk("hm.t2_m1_rdv", {31'b0, u[0].m1_if.readdatavalid}, 32'd0);
    next_cycle();                                       // t+3
    @(negedge clk_sys);
    chk("hm.t3_hps_rdata", u[0].hps_rdata, 32'h1111_1111);
    chk("hm.t3_m0_rdv", {31'b0, u[0].m0_if.readdatavalid}, 32'd0);
    next_cycle();

    // ---- m1 three back-to-back reads, RD_LAT=3 ----
    do_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      idle();
      m1_read = (cyc < 3);
      m1_address = 16'(4 + cyc);
      @(negedge clk_sys);
      chk($sformatf("b2b.c%0d_m1_wait", cyc), {31'b0, u[2].m1_if.waitrequest}, (cyc < 3) ? 32'd0 : 32'd1);
      if (cyc < 3) exp_q.push_back(mem[4 + cyc]);
      chk($sformatf("b2b.c%0d_m1_rdv", cyc), {31'b0, u[2].m1_if.readdatavalid},
          (cyc >= 3 && cyc <= 5) ? 32'd1 : 32'd0);
      if (u[2].m1_if.readdatavalid && exp_q.size() > 0) begin
        chk($sformatf("b2b.c%0d_m1_rdata", cyc), u[2].m1_if.readdata, exp_q.pop_front());
      end
      chk($sformatf("b2b.c%0d_m0_rdv", cyc), {31'b0, u[2].m0_if.readdatavalid}, 32'd0);
      next_cycle();
    end
    chk("b2b.all_returned", exp_q.size(), 32'd0);

    // ---- reset one cycle after an accepted m0 read, RD_LAT=2 ----
    do_reset();
    hps_rd = 1'b1; hps_addr = 16'h0001;
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
    @(negedge clk_sys);
    chk("rmo.hps_rdata_pre", u[1].hps_rdata, 32'h1111_1111);
    next_cycle();
    m0_read = 1'b1; m0_address = 16'h0002;             // t
    @(negedge clk_sys);
    chk("rmo.t_m0_wait", {31'b0, u[1].m0_if.waitrequest}, 32'd0);
    next_cycle();
    idle(); reset_n = 1'b0;                            // t+1
    @(negedge clk_sys);
    chk("rmo.t1_m0_rdv", {31'b0, u[1].m0_if.readdatavalid}, 32'd0);
    chk("rmo.t1_hps_rdata", u[1].hps_rdata, 32'd0);
    next_cycle();
    reset_n = 1'b1;                                     // t+2
    @(negedge clk_sys);
    chk("rmo.t2_m0_rdv", {31'b0, u[1].m0_if.readdatavalid}, 32'd0);
    next_cycle();                                       // t+3
    @(negedge clk_sys);
    chk("rmo.t3_m0_rdv", {31'b0, u[1].m0_if.readdatavalid}, 32'd0);
    chk("rmo.t3_hps_rdata", u[1].hps_rdata, 32'd0);
    next_cycle();
    m0_write = 1'b1; m0_address = 16'h0100;            // t+4 first contest
    m1_write = 1'b1; m1_address = 16'h0200;
    @(negedge clk_sys);
    chk("rmo.first_m0_wait", {31'b0, u[1].m0_if.waitrequest}, 32'd0);
    chk("rmo.first_m1_wait", {31'b0, u[1].m1_if.waitrequest}, 32'd1);
    chk("rmo.first_bus_addr", {16'b0, u[1].bus_addr}, 32'h0000_0100);
    next_cycle();
    idle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hps_ext_arb.md
Name: hps_ext_arb

Overview:
- Shares the single core-side register bus behind hps_ext (addr/wdata/rd/wr/rdata) between the HPS ext port and two internal bus masters (m0, m1), e.g. a BIOS loader and a config sequencer.
- The HPS has absolute priority and zero added latency, so hps_ext timing is preserved.
- m0 and m1 are Avalon-MM style masters with waitrequest and readdatavalid, and are served round-robin in cycles the HPS leaves idle.
- The block tags in-flight reads and routes fixed-latency read data back to the issuer.

Parameters:
AW, 16, address width
DW, 32, data width
RD_LAT, 1, cycles from bus_rd strobe to valid bus_rdata (1..4); must be 1 for hps_ext timing

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
hps_addr  in  AW  HPS address (ext_addr)
hps_wdata  in  DW  HPS write data (ext_dout)
hps_rd  in  1  HPS read strobe, single cycle
hps_wr  in  1  HPS write strobe, single cycle
hps_rdata  out  DW  captured HPS read data (to ext_din)
m0_address  in  AW  master 0 address
m0_writedata  in  DW  master 0 write data
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_waitrequest  out  1  low = m0 request accepted this cycle
m0_readdata  out  DW  master 0 read data
m0_readdatavalid  out  1  m0 read data valid, one pulse per accepted read
m1_*  (same seven signals as m0, for master 1)
bus_addr  out  AW  core bus address
bus_wdata  out  DW  core bus write data
bus_rd  out  1  core bus read strobe
bus_wr  out  1  core bus write strobe
bus_rdata  in  DW  core bus read data, valid RD_LAT cycles after bus_rd

Behaviour:
- Reset (async, reset_n=0):
  - bus_rd, bus_wr, m*_readdatavalid = 0; m*_waitrequest = 1; hps_rdata = 0.
  - Tag pipeline cleared; RR pointer last = 1, so m0 wins the first contest.
  - All combinational outputs are gated by reset_n.
- Issue selection, combinational, one access per cycle:
  - hps_rd or hps_wr high: HPS owns the bus. bus_* driven from hps_* in the same cycle; both master waitrequests stay high.
  - HPS idle, one master requesting: that master is granted.
  - HPS idle, both requesting: the master != last is granted.
  - Granted master: waitrequest = 0, its address, data and strobe are driven onto bus_*, and last <= granted index at the clock edge.
  - If a master asserts read and write together, write takes precedence and counts as one write.
  - If hps_rd and hps_wr are both high, both are forwarded unchanged; this is a protocol violation, no defined result.
  - With no request, bus_rd = bus_wr = 0; bus_addr and bus_wdata hold the m0 values (don't care).
- Read tag pipeline:
  - RD_LAT-deep shift register of {valid, id[1:0]} (id 0 = HPS, 1 = m0, 2 = m1). An entry is pushed on every issued bus_rd.
  - At pipeline output, id 0: hps_rdata <= bus_rdata (registered, holds until the next HPS read returns).
  - At pipeline output, id 1 or 2: the matching m*_readdatavalid = 1 for that cycle, and m*_readdata = bus_rdata (combinational).
- Latency:
  - HPS read: strobe at cycle t, hps_rdata valid from t+RD_LAT+1 (t+2 for RD_LAT=1). This matches hps_ext sampling two cycles after ext_rd.
  - Master read accepted at t: readdatavalid at t+RD_LAT.
  - Writes complete in the accept cycle.
- Back-to-back behaviour:
  - The capture register isolates HPS data, so a master read issued at t+1 behind an HPS read at t does not corrupt hps_rdata.
  - A master may issue a read every cycle; readdatavalid pulses return in order.
- No starvation counter: HPS strobes are sparse (io_strobe rate). Fairness is required only between m0 and m1.
- Reset mid-operation:
  - In-flight tags are discarded and no readdatavalid is produced for reads accepted before reset.
  - After release, the first contest is won by m0.

Test Plan:
- HPS write only: hps_wr=1, addr=0x0010, wdata=0xDEADBEEF -> same cycle bus_wr=1, bus_addr=0x0010, bus_wdata=0xDEADBEEF; m0/m1 waitrequest=1.
- HPS read vs m0 read: hps_rd at t (bus_rdata=0x11111111 at t+1), m0 read accepted at t+1 (bus_rdata=0x22222222 at t+2).
  -> hps_rdata=0x11111111 at t+2 and t+3.
  -> m0_readdatavalid=1 only at t+2 with m0_readdata=0x22222222.
- m0 and m1 both hold write requests for 4 cycles, HPS idle -> grants m0, m1, m0, m1; each waitrequest low exactly in its grant cycle.
- HPS write at t while m1 requests -> m1_waitrequest=1 at t; m1 accepted at t+1.
- m1 issues 3 back-to-back reads, RD_LAT=3 -> three m1_readdatavalid pulses at accept+3, in order, with matching data; no m0 pulse.
- reset_n dropped one cycle after an m0 read is accepted (RD_LAT=2), then released -> no m0_readdatavalid, hps_rdata=0, first contest won by m0.
